// File: rtl/cpu_out_tx.sv
// cpu_out_tx: FIFO-buffered serial transmitter; each 32-bit word leaves as four LSB-first 8N1 frames.
// Define CPU_OUT_TX_PARITY_EN to insert an even-parity bit per byte (8E1).
module cpu_out_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef CPU_OUT_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    state;
  logic [31:0]   shift;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic          push;
  logic          pop;
  logic          bit_end;
`ifdef CPU_OUT_TX_PARITY_EN
  logic          par;
`endif

  assign data_ready = (count != FULL);
  assign busy       = (state != S_IDLE) || (count != '0);
  assign push       = data_valid && data_ready;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  // The next word is taken either from idle or straight out of the last stop bit, so words run gap-free.
  assign pop = (count != '0) &&
               ((state == S_IDLE) || (state == S_STOP && bit_end && byte_idx == 2'd3));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (data_valid && !data_ready) overflow <= 1'b1;
    end
  end

  // tx is registered: every transition loads the line level of the state being entered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
`ifdef CPU_OUT_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            byte_idx <= 2'd0;
            baud_cnt <= '0;
            state    <= S_START;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= S_DATA;
            tx       <= shift[0];
`ifdef CPU_OUT_TX_PARITY_EN
            par      <= 1'b0;
`endif
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
`ifdef CPU_OUT_TX_PARITY_EN
            par      <= par ^ shift[0];
`endif
            if (bit_idx == 3'd7) begin
`ifdef CPU_OUT_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par ^ shift[0];
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`ifdef CPU_OUT_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= S_START;
              tx       <= 1'b0;
            end else if (pop) begin
              shift    <= mem[rd_ptr];
              byte_idx <= 2'd0;
              state    <= S_START;
              tx       <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_out_tx.md
# cpu_out_tx

Serial transmitter on the board side of the CPU's OUT port: accepts 32-bit words written by `out` instructions and transmits each one as four LSB-first 8N1 UART frames on a single line. A small FIFO decouples the CPU, which can issue `out` back-to-back, from the slow serial line. It sits between the CPU's output register and the board pin. It shares the CPU clock and reset.

## Interface
- `CLKS_PER_BIT`, 434 — clock cycles per serial bit (≥2); 434 gives 115200 baud at 50 MHz.
- `FIFO_DEPTH`, 4 — word FIFO depth; power of two, ≥2.

- `clk`  in  1  — system clock; all logic is on its rising edge.
- `clr`  in  1  — reset, synchronous, active-high.
- `data_in`  in  32  — word to transmit, from the CPU output register.
- `data_valid`  in  1  — pulse high for one cycle per `out` instruction; a word is pushed on every cycle where `data_valid` is high.
- `data_ready`  out  1  — FIFO not full; combinational from the FIFO count.
- `tx`  out  1  — serial line; registered; idles high.
- `busy`  out  1  — high when the FSM is not in IDLE or the FIFO is non-empty.
- `overflow`  out  1  — sticky; set when a word is dropped; cleared only by `clr`.

## Operation
- **FIFO:** circular buffer with `FIFO_DEPTH` entries, read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally, and a count of `$clog2(FIFO_DEPTH)+1` bits.
  - Push: `data_valid && data_ready`.
  - Push while full: the word is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: count is unchanged; both pointers advance.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** `tx`=1. If the FIFO is non-empty, pop the word into a 32-bit shift register, set byte_idx=0, and go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit_idx=0.
- **DATA:** `tx`=shift[0] for one bit time, then shift right by 1.
  - After bit_idx=7, go to PARITY if the macro is defined, otherwise to STOP.
- **STOP:** `tx`=1 for one bit time. Then:
  - if byte_idx<3: increment byte_idx and go to START;
  - if byte_idx=3 and the FIFO is non-empty: pop the next word and go to START with no idle bit;
  - otherwise go to IDLE.
- **Byte order:** data_in[7:0] first, data_in[31:24] last.
- **Counters:**
  - Baud counter runs 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state or bit change.
  - bit_idx is 3 bits; byte_idx is 2 bits.
- **Reset values:** `tx`=1, `busy`=0, `overflow`=0, `data_ready`=1; FSM in IDLE; FIFO empty; all counters 0.
- **Reset mid-frame:** the frame is abandoned and FIFO contents are discarded. `tx`=1 from the edge on which `clr` is sampled high.

## Timing
- **Push latency:** a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1, and `tx` falls after edge N+1.
- **Frame length:**
  - Without the macro: 10 bits per byte, 40 bits per word, 40·`CLKS_PER_BIT` cycles per word.
  - With the macro: 11 bits per byte, 44·`CLKS_PER_BIT` cycles per word.
- **Back-to-back words:** consecutive words are transmitted with zero gap.
- **`busy` fall:** `busy` drops at the edge after the last STOP bit time of the last queued word.
- **`data_ready`:** reflects the count after the previous edge. A pop in the current cycle does not raise `data_ready` until the next cycle.

## Configuration
- `CPU_OUT_TX_PARITY_EN`: when defined, the PARITY state is compiled in and sends one even-parity bit (XOR of the 8 data bits) between data bit 7 and STOP.
- When not defined, the PARITY state and its logic are absent and frames are plain 8N1.

## Test plan
- **Single word:** reset, `CLKS_PER_BIT`=4, push 0x12345678 → `tx` shows bytes 0x78, 0x56, 0x34, 0x12, each framed 0/LSB-first/1. `busy` falls exactly 160 cycles after `tx` first falls.
- **Back-to-back pair:** push 0xA5A5A5A5 then 0x00000000 on consecutive cycles → 80 contiguous bit times, no idle bit between words, `overflow`=0.
- **Overflow:** `FIFO_DEPTH`=4, push 6 words on 6 consecutive cycles → word 0 is popped at cycle 1; words 1–4 fill the FIFO; `data_ready`=0 at cycle 5; word 5 is dropped; `overflow`=1. Exactly 5 words are transmitted, and `overflow` stays 1 afterwards.
- **Reset mid-frame:** assert `clr` for 1 cycle during bit 3 of byte 1 with 2 words queued → `tx`=1, `busy`=0, `data_ready`=1 on the next cycle, and no further frames are sent.
- **Parity (with `CPU_OUT_TX_PARITY_EN`):** push 0x00000301 → bytes 0x01 and 0x03 carry parity 1 and 0; bytes 0x00 carry 0. `busy` lasts 176 cycles at `CLKS_PER_BIT`=4.
- **Pointer wrap:** push 9 distinct words, spaced to avoid overflow → all are transmitted in push order, bytes are correct, and `overflow`=0.
